bcd_round_controller: RTL and testbench
=======================================

# bcd_round_controller

Game-round sequencer for the BCD game, sitting directly upstream of the seven-segment display driver. It draws a pseudo-random two-digit decimal target, presents it as BCD digits Q1 (tens) and Q2 (ones), and accepts the player's binary answer on the switches when the submit button is pressed. It times each round, keeps the running correct-answer score on CORRECT, and ends the game after a fixed number of rounds.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1_000_000: cycles a synchronized button level must stay stable before it is accepted.
- ROUND_CYCLES, 500_000_000: per-round answer time limit, in cycles.
- MAX_ROUNDS, 15: rounds per game, legal range 1..15.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset, asynchronous, active-high.
- BTN_START  in  1  raw start pushbutton, asynchronous to CLK.
- BTN_SUBMIT  in  1  raw submit pushbutton, asynchronous to CLK.
- SW  in  7  player answer, unsigned binary 0..127.
- Q1  out  4  BCD tens digit of the target.
- Q2  out  4  BCD ones digit of the target.
- CORRECT  out  4  correct-answer count, 0..15.
- ROUND_ACTIVE  out  1  high while waiting for an answer.
- GAME_OVER  out  1  high in DONE.

## Operation
- **Reset values:** Q1=0, Q2=0, CORRECT=0, ROUND_ACTIVE=0, GAME_OVER=0, state=IDLE, LFSR=LFSR_SEED, round count=0, timer=0.
- **Button conditioning:** each button passes through a 2-flop synchronizer, then a debouncer that updates its level only after DEBOUNCE_CYCLES stable cycles. A rising edge of the debounced level produces a one-cycle pulse (start_p, submit_p).
- **LFSR:** 16-bit Galois LFSR, taps x^16+x^14+x^13+x^11+1. Advances every cycle in every state.
- **Target generation:** raw = lfsr[6:0]. target = raw if raw < 100, otherwise raw - 100. Q1 = target/10 and Q2 = target%10, both computed by compare/subtract with no divider. Q1 and Q2 are always legal BCD (0..9).
- **FSM states:**
  - IDLE: outputs hold. start_p → LOAD; on this transition CORRECT and round count clear to 0.
  - LOAD: one cycle. Captures target into Q1/Q2, clears the timer, then → WAIT.
  - WAIT: ROUND_ACTIVE=1 and the timer increments each cycle.
    - submit_p → CHECK, registering SW into the guess register.
    - timer == ROUND_CYCLES-1 without submit_p → CHECK with the guess forced to invalid, which scores as wrong.
    - submit_p and timeout in the same cycle: submit wins and SW is registered.
    - start_p is ignored.
  - CHECK: one cycle.
    - If guess == target, CORRECT increments, saturating at 15.
    - Round count increments.
    - If the new round count == MAX_ROUNDS → DONE, otherwise → LOAD.
  - DONE: GAME_OVER=1. Q1, Q2 and CORRECT hold. start_p → LOAD with the same clear as in IDLE.
- submit_p arriving in IDLE, LOAD, CHECK or DONE is dropped.
- RST asserted in any state immediately forces the reset values, including mid-debounce and mid-round.

## Timing
Let submit_p be high in cycle T, in WAIT.
- T+1: the design is in CHECK, with the guess registered at the T edge.
- The CORRECT update is visible from T+2.
- The design is in LOAD at T+2; the new Q1/Q2 are visible from T+3, and ROUND_ACTIVE=1 from T+3.
- On the final round, GAME_OVER=1 from T+2 and Q1/Q2 hold.
- **Timeout:** the round that enters WAIT at cycle W reaches CHECK at W+ROUND_CYCLES.
- **Start:** start_p at cycle S gives CORRECT=0 at S+1 and the first target at S+2.
- **Button latency:** from a raw button edge to its pulse is 2 synchronizer cycles + DEBOUNCE_CYCLES + 1.
- Q1, Q2 and CORRECT change only on clock edges and are glitch-free to the display driver.

## Structure
- Shared package bcd_game_pkg holds:
  - the state enum (IDLE, LOAD, WAIT, CHECK, DONE);
  - the LFSR tap constant;
  - the BCD digit type (4 bits) and the score maximum (4'd15).
- One sub-module, button_debouncer (synchronizer, debounce counter, rising-edge pulse), instantiated twice.
- The LFSR, target conversion, timer and FSM live in the top module.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, ROUND_CYCLES=50, MAX_ROUNDS=3. The bench keeps its own LFSR model.
- **Reset:** assert RST mid-WAIT → same cycle Q1=Q2=CORRECT=0, ROUND_ACTIVE=0, GAME_OVER=0.
- **Correct answer:** start, then with Q1=4, Q2=2 set SW=42 and press submit → CORRECT 0→1 two cycles after submit_p, new digits one cycle later.
- **Wrong answer and timeout:**
  - SW=41 when the target is 42 → CORRECT unchanged.
  - No submit for 50 cycles → CHECK, CORRECT unchanged, next round loads.
- **Game end and restart:**
  - Three correct rounds → CORRECT=3, GAME_OVER=1, Q1/Q2 frozen.
  - Submit in DONE → no change.
  - Start → CORRECT=0, GAME_OVER=0.
- **Debounce:** 3-cycle glitches on BTN_SUBMIT → no submit_p. A 6-cycle stable press → exactly one pulse.
- **Range and simultaneous events:**
  - Force raw=127 → Q1=2, Q2=7.
  - Force raw=99 → Q1=9, Q2=9.
  - submit_p on the timeout cycle with correct SW → counted correct.

Source files
------------

// File: rtl/bcd_game_pkg.sv
// Shared definitions for the BCD game round controller.
//   - state_t      : round sequencer states
//   - LFSR_TAPS    : Galois feedback mask for x^16+x^14+x^13+x^11+1
//   - digit_t      : one BCD digit
//   - SCORE_MAX    : saturation value of the correct-answer counter
//   - lfsr_step()  : one LFSR advance
//   - raw_to_bcd() : 7-bit raw value -> folded 0..99 target as two BCD digits
package bcd_game_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT,
        CHECK,
        DONE
    } state_t;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef logic [3:0] digit_t;

    localparam digit_t SCORE_MAX = 4'd15;

    typedef struct packed {
        digit_t     tens;
        digit_t     ones;
        logic [6:0] value;
    } bcd_pair_t;

    // Right-shifting Galois form: the bit shifted out feeds back into the tap positions.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    // Folds 100..127 onto 0..27, then finds the tens digit by comparing
    // against the multiples of ten from the top down, so no divider is built.
    function automatic bcd_pair_t raw_to_bcd(input logic [6:0] raw);
        logic [6:0] t;
        bcd_pair_t  r;
        t       = (raw >= 7'd100) ? (raw - 7'd100) : raw;
        r.tens  = 4'd0;
        r.ones  = t[3:0];
        r.value = t;
        for (int k = 9; k >= 1; k--) begin
            if ((r.tens == 4'd0) && (t >= 7'(k * 10))) begin
                r.tens = 4'(k);
                r.ones = 4'(t - 7'(k * 10));
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Conditions one raw pushbutton into a single-cycle pulse.
//   clk   : system clock
//   rst   : asynchronous active-high reset
//   btn   : raw button level, asynchronous to clk
//   pulse : one-cycle pulse on each accepted rising edge of the button
// A raw edge reaches pulse after 2 synchronizer cycles + DEBOUNCE_CYCLES + 1.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic             level;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: every register, synchronizer flops included, takes a reset
            // value so a reset clears any debounce that is in progress.
            sync_1  <= 1'b0;
            sync_2  <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            pulse   <= 1'b0;
            cnt     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the value
            // from before this edge; this is what makes sync_1 -> sync_2 a chain.
            sync_1  <= btn;
            sync_2  <= sync_1;
            level_d <= level;
            pulse   <= level & ~level_d;
            // The level flips only after the disagreeing input has been seen
            // on DEBOUNCE_CYCLES consecutive samples; any agreement restarts.
            if (sync_2 != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync_2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/bcd_round_controller.sv
// Game-round sequencer for the BCD game.
//   CLK, RST      : clock, asynchronous active-high reset
//   BTN_START     : raw start button (debounced internally)
//   BTN_SUBMIT    : raw submit button (debounced internally)
//   SW            : player answer, unsigned binary 0..127
//   Q1, Q2        : BCD tens / ones digits of the current target
//   CORRECT       : saturating count of correct answers this game
//   ROUND_ACTIVE  : high while waiting for an answer
//   GAME_OVER     : high once the last round of a game has been scored
module bcd_round_controller
    import bcd_game_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned ROUND_CYCLES    = 500_000_000,
    parameter int unsigned MAX_ROUNDS      = 15,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN_START,
    input  logic       BTN_SUBMIT,
    input  logic [6:0] SW,
    output logic [3:0] Q1,
    output logic [3:0] Q2,
    output logic [3:0] CORRECT,
    output logic       ROUND_ACTIVE,
    output logic       GAME_OVER
);

    localparam int unsigned TIMER_W = (ROUND_CYCLES > 1) ? $clog2(ROUND_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(ROUND_CYCLES - 1);
    localparam logic [3:0] ROUND_LAST = 4'(MAX_ROUNDS);

    state_t               state_q;
    state_t               state_d;
    logic                 start_p;
    logic                 submit_p;
    logic [15:0]          lfsr;
    bcd_pair_t            bcd;
    digit_t               q1_q;
    digit_t               q2_q;
    digit_t               correct_q;
    logic [3:0]           round_cnt;
    logic [TIMER_W-1:0]   timer;
    logic [6:0]           target_q;
    logic [6:0]           guess_q;
    logic                 guess_valid_q;
    logic                 timeout;
    logic                 hit;
    logic                 last_round;

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_start_btn (
        .clk   (CLK),
        .rst   (RST),
        .btn   (BTN_START),
        .pulse (start_p)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_submit_btn (
        .clk   (CLK),
        .rst   (RST),
        .btn   (BTN_SUBMIT),
        .pulse (submit_p)
    );

    assign bcd        = raw_to_bcd(lfsr[6:0]);
    assign timeout    = (timer == TIMER_LAST);
    // A timed-out round leaves guess_valid_q low, so it can never score.
    assign hit        = guess_valid_q && (guess_q == target_q);
    assign last_round = ((round_cnt + 4'd1) == ROUND_LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        ROUND_ACTIVE = 1'b0;
        GAME_OVER    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_p) state_d = LOAD;
            end
            LOAD: begin
                state_d = WAIT;
            end
            WAIT: begin
                ROUND_ACTIVE = 1'b1;
                if (submit_p || timeout) state_d = CHECK;
            end
            CHECK: begin
                state_d = last_round ? DONE : LOAD;
            end
            DONE: begin
                GAME_OVER = 1'b1;
                if (start_p) state_d = LOAD;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lfsr          <= LFSR_SEED;
            q1_q          <= 4'd0;
            q2_q          <= 4'd0;
            correct_q     <= 4'd0;
            round_cnt     <= 4'd0;
            timer         <= '0;
            target_q      <= 7'd0;
            guess_q       <= 7'd0;
            guess_valid_q <= 1'b0;
        end else begin
            lfsr <= lfsr_step(lfsr);
            case (state_q)
                IDLE, DONE: begin
                    if (start_p) begin
                        correct_q <= 4'd0;
                        round_cnt <= 4'd0;
                    end
                end
                LOAD: begin
                    q1_q     <= bcd.tens;
                    q2_q     <= bcd.ones;
                    target_q <= bcd.value;
                    timer    <= '0;
                end
                WAIT: begin
                    timer <= timer + TIMER_W'(1);
                    // Submit takes priority over a timeout in the same cycle.
                    if (submit_p) begin
                        guess_q       <= SW;
                        guess_valid_q <= 1'b1;
                    end else if (timeout) begin
                        guess_valid_q <= 1'b0;
                    end
                end
                CHECK: begin
                    if (hit && (correct_q != SCORE_MAX)) correct_q <= correct_q + 4'd1;
                    round_cnt <= round_cnt + 4'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign Q1      = q1_q;
    assign Q2      = q2_q;
    assign CORRECT = correct_q;

endmodule

// File: tb/tb_bcd_round_controller.sv
// Self-checking bench for bcd_round_controller. Stimulus predicts every
// displayed round (start of WAIT) and every game end from its own LFSR table
// and game rules and queues the expectation; a monitor compares them when the
// DUT raises ROUND_ACTIVE or GAME_OVER.
module tb_bcd_round_controller;

    localparam int D  = 4;
    localparam int RC = 50;
    localparam int MR = 3;

    logic       CLK = 1'b0;
    logic       RST;
    logic       BTN_START;
    logic       BTN_SUBMIT;
    logic [6:0] SW;
    logic [3:0] Q1;
    logic [3:0] Q2;
    logic [3:0] CORRECT;
    logic       ROUND_ACTIVE;
    logic       GAME_OVER;

    bcd_round_controller #(
        .DEBOUNCE_CYCLES (D),
        .ROUND_CYCLES    (RC),
        .MAX_ROUNDS      (MR)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .BTN_START    (BTN_START),
        .BTN_SUBMIT   (BTN_SUBMIT),
        .SW           (SW),
        .Q1           (Q1),
        .Q2           (Q2),
        .CORRECT      (CORRECT),
        .ROUND_ACTIVE (ROUND_ACTIVE),
        .GAME_OVER    (GAME_OVER)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int cyc;
        int q1;
        int q2;
        int score;
        bit over;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] tab[65536];
    int          cyc;
    int          checks   = 0;
    int          failures = 0;

    // Game model state, owned by the stimulus process.
    int score;
    int rounds;
    int w;
    int target;
    int last_evt;
    bit over;

    // Cycle index since reset release; the LFSR value in cycle c is tab[c].
    always @(posedge CLK or posedge RST) cyc <= RST ? 0 : cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic int target_of(input int c);
        logic [6:0] raw;
        raw = tab[c][6:0];
        return (raw < 7'd100) ? int'(raw) : int'(raw) - 100;
    endfunction

    function automatic int wrong_of(input int t);
        return (t == 0) ? 1 : t - 1;
    endfunction

    task automatic push_exp(input int c, input int t, input bit ov);
        exp_t e;
        e.cyc   = c;
        e.q1    = t / 10;
        e.q2    = t % 10;
        e.score = score;
        e.over  = ov;
        sb.push_back(e);
        last_evt = c;
    endtask

    // LOAD in load_c captures that cycle's LFSR; WAIT starts one cycle later.
    task automatic push_round(input int load_c);
        target = target_of(load_c);
        w      = load_c + 1;
        push_exp(w, target, 1'b0);
    endtask

    task automatic finish_round(input int check_c, input bit valid, input int guess);
        if (valid && (guess == target) && (score < 15)) score++;
        rounds++;
        if (rounds == MR) begin
            over = 1'b1;
            push_exp(check_c + 1, target, 1'b1);
        end else begin
            push_round(check_c + 1);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge CLK);
    endtask

    // Clean press: raised in the current cycle R, pulse appears in R+D+3.
    task automatic hold_button(input bit is_start);
        if (is_start) BTN_START = 1'b1; else BTN_SUBMIT = 1'b1;
        repeat (6) @(negedge CLK);
        if (is_start) BTN_START = 1'b0; else BTN_SUBMIT = 1'b0;
        repeat (D + 4) @(negedge CLK);
    endtask

    task automatic start_game();
        int p;
        p      = cyc + D + 3;
        score  = 0;
        rounds = 0;
        over   = 1'b0;
        push_round(p + 1);
        hold_button(1'b1);
    endtask

    task automatic submit(input int sw);
        int p;
        SW = 7'(sw);
        p  = cyc + D + 3;
        finish_round(p + 1, 1'b1, sw);
        hold_button(1'b0);
    endtask

    task automatic timeout_round();
        int c;
        c = w + RC;
        finish_round(c, 1'b0, 0);
        wait_until(c + 2);
    endtask

    // Submit pulse lands exactly on the timer's last cycle.
    task automatic simultaneous_round();
        wait_until(w + RC - 1 - D - 3);
        submit(target);
    endtask

    // Delay the start press until the first LOAD will see the wanted raw value.
    task automatic start_at_raw(input int raw_want);
        int n;
        n = 0;
        while ((int'(tab[cyc + D + 4][6:0]) != raw_want) && (n < 5000)) begin
            @(negedge CLK);
            n++;
        end
        if (n == 5000) begin
            checks++;
            failures++;
            $display("FAIL raw_search: raw %0d not reached in %0d cycles", raw_want, n);
        end
        start_game();
    endtask

    task automatic glitch_submit();
        BTN_SUBMIT = 1'b1;
        repeat (3) @(negedge CLK);
        BTN_SUBMIT = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    // Monitor: compare on every rising ROUND_ACTIVE or GAME_OVER.
    initial begin
        bit   ra_prev;
        bit   go_prev;
        exp_t e;
        ra_prev = 1'b0;
        go_prev = 1'b0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                ra_prev = 1'b0;
                go_prev = 1'b0;
            end else begin
                if ((ROUND_ACTIVE && !ra_prev) || (GAME_OVER && !go_prev)) begin
                    check("event_expected", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("event_cycle", cyc, e.cyc);
                        check("q1", Q1, e.q1);
                        check("q2", Q2, e.q2);
                        check("correct", CORRECT, e.score);
                        check("game_over", GAME_OVER, e.over);
                    end
                end
                ra_prev = ROUND_ACTIVE;
                go_prev = GAME_OVER;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int maxd;
        RST        = 1'b1;
        BTN_START  = 1'b0;
        BTN_SUBMIT = 1'b0;
        SW         = 7'd0;
        tab[0]     = 16'hACE1;
        for (int i = 1; i < 65536; i++)
            tab[i] = {1'b0, tab[i-1][15:1]} ^ (tab[i-1][0] ? 16'hB400 : 16'h0000);

        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("reset_q1", Q1, 0);
        check("reset_q2", Q2, 0);
        check("reset_correct", CORRECT, 0);
        check("reset_round_active", ROUND_ACTIVE, 0);
        check("reset_game_over", GAME_OVER, 0);

        // Reset in the middle of a round.
        start_game();
        wait_until(w + 5);
        check("mid_wait_round_active", ROUND_ACTIVE, 1);
        #1 RST = 1'b1;
        #1;
        check("rst_q1", Q1, 0);
        check("rst_q2", Q2, 0);
        check("rst_correct", CORRECT, 0);
        check("rst_round_active", ROUND_ACTIVE, 0);
        check("rst_game_over", GAME_OVER, 0);
        sb.delete();
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        // Game A: target 42 answered right, then a wrong answer, then a timeout.
        start_at_raw(42);
        wait_until(w);
        check("target42_q1", Q1, 4);
        check("target42_q2", Q2, 2);
        submit(target);
        submit(wrong_of(target));
        timeout_round();
        wait_until(last_evt + 1);
        check("game_a_over", GAME_OVER, 1);

        // Submit while DONE is dropped.
        SW = 7'(target);
        hold_button(1'b0);
        check("done_submit_q1", Q1, target / 10);
        check("done_submit_q2", Q2, target % 10);
        check("done_submit_correct", CORRECT, score);
        check("done_submit_game_over", GAME_OVER, 1);

        // Game B: raw 127 folds to 27; three correct rounds incl. submit on the timeout cycle.
        start_at_raw(127);
        wait_until(w);
        check("raw127_q1", Q1, 2);
        check("raw127_q2", Q2, 7);
        check("restart_correct", CORRECT, 0);
        check("restart_game_over", GAME_OVER, 0);
        submit(target);
        simultaneous_round();
        submit(target);
        wait_until(last_evt + 1);
        check("game_b_correct", CORRECT, 3);
        check("game_b_over", GAME_OVER, 1);
        repeat (10) @(negedge CLK);
        check("frozen_q1", Q1, target / 10);
        check("frozen_q2", Q2, target % 10);

        // Game C: raw 99; short glitches must not submit, so round 1 times out.
        start_at_raw(99);
        wait_until(w);
        check("raw99_q1", Q1, 9);
        check("raw99_q2", Q2, 9);
        SW = 7'(target);
        glitch_submit();
        glitch_submit();
        glitch_submit();
        timeout_round();
        submit(target);
        submit(wrong_of(target));

        // Randomized games.
        for (int g = 0; g < 5; g++) begin
            repeat ($urandom_range(0, 20)) @(negedge CLK);
            start_game();
            while (!over) begin
                k = $urandom_range(0, 4);
                if (k == 3) begin
                    timeout_round();
                end else if (k == 4) begin
                    simultaneous_round();
                end else begin
                    maxd = w + RC - 1 - (D + 3) - cyc;
                    if (maxd < 0) maxd = 0;
                    repeat ($urandom_range(0, maxd)) @(negedge CLK);
                    submit((k == 0) ? target : (k == 1) ? wrong_of(target) : int'($urandom_range(0, 127)));
                end
            end
        end

        for (int i = 0; (i < 200) && (sb.size() != 0); i++) @(negedge CLK);
        check("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
